// File: rtl/bus_arbit_pkg.sv
// Shared types and helpers for the N-master bus arbiter.
// Holds arbitration mode codes, the per-edge decision enum and index helpers.
package bus_arbit_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    localparam int MAX_M     = 8;

    // Which of the four ownership rules fired on a given edge
    typedef enum logic [1:0] {
        DEC_IDLE,
        DEC_RETAIN,
        DEC_EXPIRE,
        DEC_SWITCH
    } arb_dec_e;

    // clog2 with a floor of 1 so a register is never zero bits wide
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    function automatic logic [2:0] onehot_to_idx(input logic [MAX_M-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_M; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_arbit_pick.sv
// Combinational selector: first set candidate searching upward from a start index.
// Ports: i_cand (candidates), i_start (search origin), i_mode (RR=1), o_idx, o_valid.
module bus_arbit_pick
    import bus_arbit_pkg::*;
#(
    parameter int NUM_M = 4,
    parameter int IW    = 2
) (
    input  logic [NUM_M-1:0] i_cand,
    input  logic [IW-1:0]    i_start,
    input  logic             i_mode,
    output logic [IW-1:0]    o_idx,
    output logic             o_valid
);

    logic [IW-1:0]    w_start;
    logic [NUM_M-1:0] w_oh;
    logic [MAX_M-1:0] w_oh8;
    logic [2:0]       w_idx8;
    logic             w_found;
    int               w_pos;

    // Fixed priority always searches from master 0
    assign w_start = (i_mode == 1'(ARB_FIXED)) ? '0 : i_start;

    always_comb begin
        w_oh    = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < NUM_M; k++) begin
            w_pos = (int'(w_start) + k) % NUM_M;
            if (!w_found && i_cand[w_pos[IW-1:0]]) begin
                w_oh[w_pos[IW-1:0]] = 1'b1;
                w_found             = 1'b1;
            end
        end
    end

    always_comb begin
        w_oh8              = '0;
        w_oh8[NUM_M-1:0]   = w_oh;
        w_idx8             = onehot_to_idx(w_oh8);
    end

    assign o_idx   = w_idx8[IW-1:0];
    assign o_valid = w_found;

endmodule

// File: rtl/bus_arbit_n.sv
// N-master bus arbiter with fixed or round-robin priority and optional hold limit.
// Ports: clk, reset_n (sync, active-low), req[NUM_M], grant (one-hot), grant_id.
module bus_arbit_n
    import bus_arbit_pkg::*;
#(
    parameter int NUM_M    = 4,
    parameter int RR_MODE  = 0,
    parameter int MAX_HOLD = 0,
    localparam int IW      = idx_width(NUM_M),
    localparam int HW      = idx_width(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NUM_M-1:0] req,
    output logic [NUM_M-1:0] grant,
    output logic [IW-1:0]    grant_id
);

    logic [IW-1:0]    r_owner;
    logic [NUM_M-1:0] r_grant;
    logic [HW-1:0]    r_hold;

    logic             w_own_req;
    logic [NUM_M-1:0] w_others;
    logic [NUM_M-1:0] w_cand;
    logic             w_idle;
    logic             w_expired;
    logic             w_retain;
    logic [IW-1:0]    w_start;
    logic [IW-1:0]    w_pick_idx;
    logic             w_pick_valid;
    arb_dec_e         w_dec;
    logic [IW-1:0]    w_nxt_owner;
    logic [HW-1:0]    w_nxt_hold;
    logic [NUM_M-1:0] w_nxt_grant;

    assign w_own_req = req[r_owner];
    // r_grant is the owner's one-hot, so masking with it drops the owner bit
    assign w_others  = req & ~r_grant;
    assign w_idle    = ~|req;

    // >= rather than == so a counter saturated by a lone requester
    // still expires as soon as a competitor shows up
    assign w_expired = (MAX_HOLD > 0) && w_own_req && |w_others
                     && (int'(r_hold) >= MAX_HOLD - 1);
    assign w_retain  = w_own_req && !w_expired;

    assign w_cand    = w_own_req ? w_others : req;

    // Round-robin pointer is the owner itself: search starts just past it
    assign w_start   = (int'(r_owner) == NUM_M - 1) ? '0 : r_owner + 1'b1;

    bus_arbit_pick #(
        .NUM_M (NUM_M),
        .IW    (IW)
    ) u_pick (
        .i_cand  (w_cand),
        .i_start (w_start),
        .i_mode  (RR_MODE == ARB_RR),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_dec = DEC_SWITCH;
        unique case (1'b1)
            w_idle:    w_dec = DEC_IDLE;
            w_retain:  w_dec = DEC_RETAIN;
            w_expired: w_dec = DEC_EXPIRE;
            default:   w_dec = DEC_SWITCH;
        endcase
    end

    always_comb begin
        w_nxt_owner = r_owner;
        w_nxt_hold  = r_hold;
        unique case (w_dec)
            DEC_IDLE: begin
                w_nxt_owner = '0;
                w_nxt_hold  = '0;
            end
            DEC_RETAIN: begin
                if (int'(r_hold) < MAX_HOLD) begin
                    w_nxt_hold = r_hold + 1'b1;
                end
            end
            DEC_EXPIRE, DEC_SWITCH: begin
                w_nxt_owner = w_pick_valid ? w_pick_idx : '0;
                w_nxt_hold  = '0;
            end
            default: begin
                w_nxt_owner = '0;
                w_nxt_hold  = '0;
            end
        endcase
    end

    always_comb begin
        w_nxt_grant              = '0;
        w_nxt_grant[w_nxt_owner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_owner <= '0;
            r_grant <= {{(NUM_M-1){1'b0}}, 1'b1};
            r_hold  <= '0;
        end else begin
            r_owner <= w_nxt_owner;
            r_grant <= w_nxt_grant;
            r_hold  <= w_nxt_hold;
        end
    end

    assign grant    = r_grant;
    assign grant_id = r_owner;

endmodule

// File: tb/tb_bus_arbit_n.sv
// Self-checking bench for bus_arbit_n: four configurations share one req bus
// and are stepped against a behavioural ownership model every cycle.
module tb_bus_arbit_n;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] g   [4];
    logic [1:0] gid [4];

    int checks;
    int errors;

    // per-instance configuration and model state
    int rrp [4] = '{0, 1, 0, 1};
    int mhp [4] = '{0, 0, 4, 2};
    int m_own [4];
    int m_cnt [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bus_arbit_n #(.NUM_M(4), .RR_MODE(0), .MAX_HOLD(0)) u_fix (
        .clk(clk), .reset_n(reset_n), .req(req),
        .grant(g[0]), .grant_id(gid[0]));

    bus_arbit_n #(.NUM_M(4), .RR_MODE(1), .MAX_HOLD(0)) u_rr (
        .clk(clk), .reset_n(reset_n), .req(req),
        .grant(g[1]), .grant_id(gid[1]));

    bus_arbit_n #(.NUM_M(4), .RR_MODE(0), .MAX_HOLD(4)) u_hold (
        .clk(clk), .reset_n(reset_n), .req(req),
        .grant(g[2]), .grant_id(gid[2]));

    bus_arbit_n #(.NUM_M(4), .RR_MODE(1), .MAX_HOLD(2)) u_rrh (
        .clk(clk), .reset_n(reset_n), .req(req),
        .grant(g[3]), .grant_id(gid[3]));

    // Ownership rules stated directly: keep, expire, re-pick, or park.
    task automatic model_step(input int rr, input int mh, input logic [3:0] r,
                              input int own, input int cnt,
                              output int nown, output int ncnt);
        logic [3:0] others;
        logic [3:0] cand;
        logic       own_req;
        logic       expired;
        int         idx;
        own_req     = r[own];
        others      = r;
        others[own] = 1'b0;
        expired     = (mh > 0) && own_req && (cnt >= mh - 1) && (others != 0);
        nown = 0;
        ncnt = 0;
        if (r == 4'b0000) begin
            nown = 0;
        end else if (own_req && !expired) begin
            nown = own;
            ncnt = (cnt < mh) ? cnt + 1 : cnt;
        end else begin
            cand = own_req ? others : r;
            nown = -1;
            for (int k = 0; k < 4; k++) begin
                idx = rr ? (own + 1 + k) % 4 : k;
                if (nown < 0 && cand[idx]) nown = idx;
            end
            if (nown < 0) nown = 0;
        end
    endtask

    // Drive one cycle, advance the model, then compare every instance.
    task automatic tick(input logic [3:0] r, input logic rn);
        int no;
        int nc;
        logic [3:0] exp_g;
        req     = r;
        reset_n = rn;
        @(posedge clk);
        for (int d = 0; d < 4; d++) begin
            if (!rn) begin
                m_own[d] = 0;
                m_cnt[d] = 0;
            end else begin
                model_step(rrp[d], mhp[d], r, m_own[d], m_cnt[d], no, nc);
                m_own[d] = no;
                m_cnt[d] = nc;
            end
        end
        #1;
        for (int d = 0; d < 4; d++) begin
            exp_g = 4'b0001 << m_own[d];
            checks++;
            if (g[d] !== exp_g || gid[d] !== 2'(m_own[d])) begin
                errors++;
                $display("FAIL model dut%0d req=%b grant=%b id=%0d want grant=%b id=%0d",
                         d, r, g[d], gid[d], exp_g, m_own[d]);
            end
            checks++;
            if ($countones(g[d]) != 1) begin
                errors++;
                $display("FAIL onehot dut%0d grant=%b want exactly one bit", d, g[d]);
            end
        end
    endtask

    task automatic test_reset();
        tick(4'b1110, 1'b0);
        tick(4'b1110, 1'b0);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (g[d] !== 4'b0001 || gid[d] !== 2'd0) begin
                errors++;
                $display("FAIL reset dut%0d grant=%b id=%0d want 0001 id 0", d, g[d], gid[d]);
            end
        end
        tick(4'b0000, 1'b1);
        checks++;
        if (g[0] !== 4'b0001) begin
            errors++;
            $display("FAIL reset_release grant=%b want 0001", g[0]);
        end
    endtask

    task automatic test_fixed();
        tick(4'b0110, 1'b1);
        checks++;
        if (g[0] !== 4'b0010) begin
            errors++;
            $display("FAIL fixed_lowest grant=%b want 0010", g[0]);
        end
        tick(4'b0111, 1'b1);
        checks++;
        if (g[0] !== 4'b0010) begin
            errors++;
            $display("FAIL fixed_keep grant=%b want 0010", g[0]);
        end
        tick(4'b0101, 1'b1);
        checks++;
        if (g[0] !== 4'b0001) begin
            errors++;
            $display("FAIL fixed_drop grant=%b want 0001", g[0]);
        end
    endtask

    task automatic test_round_robin();
        int want [5] = '{0, 1, 2, 3, 0};
        logic [3:0] r;
        tick(4'b0000, 1'b1);
        checks++;
        if (gid[1] !== 2'(want[0])) begin
            errors++;
            $display("FAIL rr_seq0 id=%0d want %0d", gid[1], want[0]);
        end
        for (int i = 1; i < 5; i++) begin
            r = 4'b1111;
            r[want[i-1]] = 1'b0;
            tick(r, 1'b1);
            checks++;
            if (gid[1] !== 2'(want[i])) begin
                errors++;
                $display("FAIL rr_seq%0d id=%0d want %0d", i, gid[1], want[i]);
            end
        end
    endtask

    task automatic test_hold_limit();
        int w;
        tick(4'b0000, 1'b1);
        for (int t = 1; t <= 16; t++) begin
            tick(4'b0011, 1'b1);
            w = (t / 4) % 2;
            checks++;
            if (gid[2] !== 2'(w)) begin
                errors++;
                $display("FAIL hold_t%0d id=%0d want %0d", t, gid[2], w);
            end
        end
    endtask

    task automatic test_park();
        tick(4'b0100, 1'b1);
        checks++;
        if (g[0] !== 4'b0100) begin
            errors++;
            $display("FAIL park_own2 grant=%b want 0100", g[0]);
        end
        tick(4'b0000, 1'b1);
        checks++;
        if (g[0] !== 4'b0001) begin
            errors++;
            $display("FAIL park_idle grant=%b want 0001", g[0]);
        end
        tick(4'b0100, 1'b1);
        checks++;
        if (g[0] !== 4'b0100) begin
            errors++;
            $display("FAIL park_regrant grant=%b want 0100", g[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] w;
        for (int i = 0; i < 3; i++) tick(4'b1000, 1'b1);
        tick(4'b1000, 1'b0);
        checks++;
        if (g[2] !== 4'b0001 || gid[2] !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset grant=%b want 0001", g[2]);
        end
        tick(4'b1000, 1'b1);
        checks++;
        if (g[2] !== 4'b1000) begin
            errors++;
            $display("FAIL mid_return grant=%b want 1000", g[2]);
        end
        // fresh owner 3 under contention keeps exactly four cycles
        for (int t = 1; t <= 4; t++) begin
            tick(4'b1001, 1'b1);
            w = (t < 4) ? 4'b1000 : 4'b0001;
            checks++;
            if (g[2] !== w) begin
                errors++;
                $display("FAIL mid_hold_t%0d grant=%b want %b", t, g[2], w);
            end
        end
        // saturate master 0 alone, then reset must clear the hold count
        for (int i = 0; i < 6; i++) tick(4'b0001, 1'b1);
        tick(4'b0001, 1'b0);
        for (int t = 1; t <= 4; t++) begin
            tick(4'b0011, 1'b1);
            w = (t < 4) ? 4'b0001 : 4'b0010;
            checks++;
            if (g[2] !== w) begin
                errors++;
                $display("FAIL clr_hold_t%0d grant=%b want %b", t, g[2], w);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic       rn;
        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 6) r = 4'($urandom_range(0, 15));
            rn = ($urandom_range(0, 99) != 0);
            tick(r, rn);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        req     = 4'b0000;
        reset_n = 1'b0;
        test_reset();
        test_fixed();
        test_round_robin();
        test_hold_limit();
        test_park();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbit_n.md
# bus_arbit_n

Parametrised N-master bus arbiter, the successor to the two-master arbiter in the simple memory/bus subsystem. It grants one master at a time, selected by fixed or round-robin priority. The current owner keeps the bus for as long as it requests, optionally bounded by a hold limit. When no master requests, the grant parks on master 0. Its one-hot grant drives the bus mux and address/data select logic in the bus block.

## Interface
Parameters:
- NUM_M, 4: number of masters, legal 2..8.
- RR_MODE, 0: 0 = fixed priority (master 0 highest); 1 = round-robin.
- MAX_HOLD, 0: 0 = owner keeps the grant indefinitely while requesting; N>0 = owner loses the grant after N consecutive granted cycles if another master requests.

Ports:
- clk, input, 1: single clock; all state updates on posedge.
- reset_n, input, 1: reset, synchronous and active-low.
- req, input, NUM_M: request per master, bit i = master i.
- grant, output, NUM_M: registered, always exactly one-hot.
- grant_id, output, clog2(NUM_M): binary index of the set grant bit, registered.

## Operation
- State: owner (= grant_id), hold_cnt (saturating at MAX_HOLD; width clog2(MAX_HOLD+1), minimum 1).
- Reset (reset_n=0 at posedge): grant=1 (master 0), grant_id=0, hold_cnt=0. Reset wins over any req, including mid-transfer.
- Each posedge, with reset_n=1, next owner is chosen in priority order:
  1. Retain: req[owner]=1 and not expired -> owner unchanged, hold_cnt+1 (saturating).
  2. Expired: MAX_HOLD>0, req[owner]=1, hold_cnt==MAX_HOLD-1, and some other req bit set.
     - The candidate set is req with the owner bit cleared.
     - Pick from the candidate set (rule 3 selection). hold_cnt=0.
  3. Re-arbitrate: req[owner]=0 and req!=0 -> pick from req, hold_cnt=0.
     - Fixed mode: lowest set index.
     - RR mode: first set index searching owner+1, owner+2, … modulo NUM_M.
  4. Idle: req==0 -> park, owner=0, hold_cnt=0.
- The expiry check applies only if another master requests. A lone requester keeps the grant indefinitely, and hold_cnt saturates.
- The round-robin pointer is the owner itself; there is no separate pointer register. After parking, the search starts at master 1.
- Fixed mode with MAX_HOLD>0 guarantees master 0 cannot starve master 1..N-1 beyond MAX_HOLD cycles.
- grant must never be zero or multi-hot, in any cycle, in any mode.

## Timing
- Latency is one cycle: a req change sampled at edge k is reflected in grant after edge k.
- A new owner sees grant for at least 1 cycle. It sees at most MAX_HOLD consecutive cycles while any other master requests.
- The owner dropping req at edge k: the new grant is visible after edge k. There are no dead cycles between owners.
- Simultaneous owner drop and new requests: resolved in the same edge by rule 3.
- Parked grant on master 0 with req[0]=1 at the next edge counts as a retain. hold_cnt continues from its parked value 0.

## Structure
- Package bus_arbit_pkg holds:
  - localparams ARB_FIXED=0 and ARB_RR=1;
  - a function onehot_to_idx;
  - a function idx_width (clog2 with minimum 1).
- Sub-module bus_arbit_pick is combinational. Inputs: candidate vector, start index, mode. Output: selected index and valid. Fixed mode uses start=0.
- The top level holds owner/hold_cnt registers, the rule 1–4 decision, and the one-hot decode.

## Test plan
- Reset: with reset_n=0 for 2 cycles and req=4'b1110, expect grant=4'b0001 and grant_id=0. Release with req=0; grant stays 4'b0001.
- Fixed priority, NUM_M=4, MAX_HOLD=0:
  - req=4'b0110 -> grant=4'b0010.
  - Raise req[0] while req[1] is held -> grant stays 4'b0010.
  - Drop req[1] -> grant=4'b0001 (bit 0 now the lowest requester).
- Round-robin, RR_MODE=1: hold req=4'b1111, each owner dropping its req for one cycle after 1 granted cycle. Expect the grant_id sequence 0,1,2,3,0.
- Hold limit, RR_MODE=0, MAX_HOLD=4: constant req=4'b0011. Expect the grant to alternate between masters 0 and 1, exactly 4 cycles each.
- Idle parking: owner 2 drops req with req=0 -> grant=4'b0001 next cycle. Then req=4'b0100 -> grant=4'b0100 one cycle later.
- Reset mid-operation: owner 3 is mid-hold with req=4'b1000, and reset_n=0 for 1 cycle. Expect grant=4'b0001 after that edge and hold_cnt cleared. Grant returns to master 3 on the first edge with reset_n=1.
